packet_serializer: RTL

//   Transmit-side counterpart of the packet reassembly buffer: accepts one whole packet_types::packet_element_t
//   and emits its flits one per handshake as HEAD, BODY..., TAIL with consistent packet_id/flit_num.

---
 rtl/packet_serializer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/packet_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : packet_serializer (with its flit / packet type packages)
// Brief    : Takes one whole packet and emits it flit by flit as
//            HEAD, BODY..., TAIL. It rewrites each header with a locally
//            allocated packet_id and a running flit_num.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Link-level flit format shared by every flit producer and consumer.
// ----------------------------------------------------------------------------
package types;
    localparam int PAYLOAD_W   = 32;
    localparam int PACKET_ID_W = 4;
    localparam int FLIT_NUM_W  = 3;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flittype_t;

    typedef logic [PACKET_ID_W-1:0] packet_id_t;
    typedef logic [FLIT_NUM_W-1:0]  flit_num_t;

    typedef struct packed {
        flittype_t              flittype;
        packet_id_t             packet_id;
        flit_num_t              flit_num;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

// ----------------------------------------------------------------------------
// Whole-packet container, the same shape the reassembly buffer produces.
// ----------------------------------------------------------------------------
package packet_types;
    localparam int BUFFER_DEPTH = 8;
    localparam int TAIL_INDEX_W = 4;

    typedef struct packed {
        types::flit_t [BUFFER_DEPTH-1:0] buffer;
        logic [TAIL_INDEX_W-1:0]         tail_index;
    } packet_element_t;
endpackage

// ----------------------------------------------------------------------------
// MAX_FLITS must lie in [2, packet_types::BUFFER_DEPTH].
// ----------------------------------------------------------------------------
module packet_serializer #(
    parameter int MAX_FLITS      = 8,
    parameter int PACKET_ID_INIT = 0
) (
    input  logic                          nocclk,
    input  logic                          rst_n,
    input  packet_types::packet_element_t packet_in,
    input  logic                          packet_in_valid,
    output logic                          packet_in_ready,
    output types::flit_t                  flit_out,
    output logic                          flit_out_valid,
    input  logic                          flit_out_ready,
    output logic                          busy,
    output logic                          drop_error,
    output logic [15:0]                   sent_count
);

    localparam int DEPTH = packet_types::BUFFER_DEPTH;
    localparam int TIW   = packet_types::TAIL_INDEX_W;
    localparam int PW    = types::PAYLOAD_W;
    localparam int FNW   = types::FLIT_NUM_W;

    typedef logic [TIW-1:0] len_t;

    localparam len_t              C_MIN_LEN = len_t'(2);
    localparam len_t              C_MAX_LEN = len_t'(MAX_FLITS);
    localparam len_t              C_LEN_ONE = len_t'(1);
    localparam types::packet_id_t C_ID_INIT = types::packet_id_t'(PACKET_ID_INIT);
    localparam types::packet_id_t C_ID_ONE  = types::packet_id_t'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                   state_q;
    logic [DEPTH-1:0][PW-1:0] pay_q;       // snapshot of the accepted payloads
    len_t                     len_q;       // flit count of the held packet
    len_t                     idx_q;       // index of the flit on flit_out
    types::packet_id_t        next_id_q;   // id for the held / next packet
    types::flit_t             flit_q;
    logic                     flit_valid_q;
    logic                     drop_q;
    logic [15:0]              sent_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0][PW-1:0] in_pay_d;
    logic                     unused_in_hdr;
    logic                     len_bad_d;
    logic                     fire_d;
    logic                     last_d;
    len_t                     idx_nxt_d;
    types::flit_t             head_flit_d;
    types::flit_t             nxt_flit_d;

    // Only the payloads of the incoming flits are kept. Their headers are
    // regenerated here, so the incoming header bits are deliberately ignored.
    always_comb begin
        in_pay_d      = '0;
        unused_in_hdr = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in_pay_d[k]   = packet_in.buffer[k].payload;
            unused_in_hdr = unused_in_hdr ^ (^{packet_in.buffer[k].flittype,
                                               packet_in.buffer[k].packet_id,
                                               packet_in.buffer[k].flit_num});
        end
    end

    // Accept-time length check, output handshake decode and next-flit build.
    always_comb begin
        len_bad_d = (packet_in.tail_index < C_MIN_LEN) ||
                    (packet_in.tail_index > C_MAX_LEN);
        fire_d    = flit_valid_q & flit_out_ready;
        last_d    = (idx_q == (len_q - C_LEN_ONE));
        idx_nxt_d = idx_q + C_LEN_ONE;

        head_flit_d           = '0;
        head_flit_d.flittype  = types::HEAD;
        head_flit_d.packet_id = next_id_q;
        head_flit_d.flit_num  = '0;
        head_flit_d.payload   = in_pay_d[0];

        // The flit after a non-final handshake is the TAIL once it reaches
        // the last index; otherwise it is a BODY.
        nxt_flit_d           = '0;
        nxt_flit_d.flittype  = (idx_nxt_d == (len_q - C_LEN_ONE)) ? types::TAIL
                                                                   : types::BODY;
        nxt_flit_d.packet_id = next_id_q;
        nxt_flit_d.flit_num  = idx_nxt_d[FNW-1:0];
        nxt_flit_d.payload   = pay_q[idx_nxt_d[FNW-1:0]];
    end

    // Serializer FSM. All outputs except ready/busy are registered here.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pay_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            next_id_q    <= C_ID_INIT;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            sent_q       <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (packet_in_valid) begin
                        if (len_bad_d) begin
                            // Bad length: discard and report. The id is not
                            // consumed and nothing is emitted.
                            drop_q <= 1'b1;
                        end else begin
                            pay_q        <= in_pay_d;
                            len_q        <= packet_in.tail_index;
                            idx_q        <= '0;
                            flit_q       <= head_flit_d;
                            flit_valid_q <= 1'b1;
                            state_q      <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    // Without a handshake flit_q / flit_valid_q simply hold.
                    if (fire_d) begin
                        if (last_d) begin
                            flit_q       <= '0;
                            flit_valid_q <= 1'b0;
                            idx_q        <= '0;
                            next_id_q    <= next_id_q + C_ID_ONE;
                            sent_q       <= sent_q + 16'd1;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q  <= idx_nxt_d;
                            flit_q <= nxt_flit_d;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    flit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign packet_in_ready = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign flit_out        = flit_q;
    assign flit_out_valid  = flit_valid_q;
    assign drop_error      = drop_q;
    assign sent_count      = sent_q;

endmodule

`default_nettype wire
